// File: rtl/date_pkg.sv
// date_pkg: shared FSM state, digit positions and calendar helpers for date entry
package date_pkg;
  typedef enum logic [1:0] {IDLE, EDIT, CHECK} state_t;
  localparam int MON_T = 5;
  localparam int MON_O = 4;
  localparam int DAY_T = 3;
  localparam int DAY_O = 2;
  localparam int YR_T  = 1;
  localparam int YR_O  = 0;
  function automatic logic is_leap_bcd(input logic [7:0] yy);
    return yy[4] ? (yy[3:0] == 4'd2 || yy[3:0] == 4'd6)
                 : (yy[3:0] == 4'd0 || yy[3:0] == 4'd4 || yy[3:0] == 4'd8);
  endfunction
  function automatic logic [7:0] days_in_month(input logic [7:0] bcd_month, input logic leap);
    return bcd_month == 8'h02 ? (leap ? 8'h29 : 8'h28)
         : (bcd_month == 8'h04 || bcd_month == 8'h06 || bcd_month == 8'h09 || bcd_month == 8'h11) ? 8'h30
         : 8'h31;
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronise and debounce an active-low key, one-cycle pulse per accepted press
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s2, lvl, lvl_d, armed;
  logic [CW-1:0] cnt;
  // sync, count disagreement with the accepted level, flag accepted falling edges once a release was seen
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      lvl   <= 1'b1;
      lvl_d <= 1'b1;
      armed <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= key_n;
      s2    <= s1;
      lvl_d <= lvl;
      armed <= armed | (s2 & lvl);
      press <= armed & lvl_d & ~lvl;
      if (s2 == lvl) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt <= '0;
        lvl <= s2;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/bcd_date_entry.sv
// bcd_date_entry: key/switch driven MMDDYY BCD date entry with validation and commit
module bcd_date_entry
  import date_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter logic [23:0] DEFAULT_DATE    = 24'h061300
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        key_next_n,
  input  logic        key_cancel_n,
  input  logic [3:0]  sw_digit,
  output logic [23:0] disp_bcd,
  output logic [23:0] date_bcd,
  output logic [5:0]  cursor_oh,
  output logic        editing,
  output logic        done,
  output logic        err_digit,
  output logic        err_date
);
  state_t      state;
  logic [23:0] work;
  logic [3:0]  sw1, sw;
  logic        next_press, cancel_press, valid;
  logic [7:0]  mon, day, yr;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk(clk), .reset_n(reset_n), .key_n(key_next_n), .press(next_press));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancel (
    .clk(clk), .reset_n(reset_n), .key_n(key_cancel_n), .press(cancel_press));
  // two-stage synchroniser for the digit switches
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {sw1, sw} <= '0;
    else {sw1, sw} <= {sw_digit, sw1};
  assign mon      = {work[MON_T*4 +: 4], work[MON_O*4 +: 4]};
  assign day      = {work[DAY_T*4 +: 4], work[DAY_O*4 +: 4]};
  assign yr       = {work[YR_T*4 +: 4], work[YR_O*4 +: 4]};
  assign valid    = mon != 8'h00 && mon <= 8'h12 && day != 8'h00 &&
                    day <= days_in_month(mon, is_leap_bcd(yr));
  assign disp_bcd = editing ? work : date_bcd;
  // entry FSM: IDLE waits for a start press, EDIT fills digits MSB first, CHECK validates and commits
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      work      <= DEFAULT_DATE;
      date_bcd  <= DEFAULT_DATE;
      cursor_oh <= '0;
      editing   <= 1'b0;
      done      <= 1'b0;
      err_digit <= 1'b0;
      err_date  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (next_press) begin
          state     <= EDIT;
          editing   <= 1'b1;
          cursor_oh <= 6'b100000;
          work      <= date_bcd;
          err_digit <= 1'b0;
          err_date  <= 1'b0;
        end
        EDIT: if (cancel_press) begin
          state     <= IDLE;
          editing   <= 1'b0;
          cursor_oh <= '0;
          err_digit <= 1'b0;
          err_date  <= 1'b0;
        end else if (next_press) begin
          if (sw > 4'd9) err_digit <= 1'b1;
          else begin
            for (int i = 0; i < 6; i++) if (cursor_oh[i]) work[i*4 +: 4] <= sw;
            err_digit <= 1'b0;
            err_date  <= 1'b0;
            if (cursor_oh[0]) state <= CHECK;
            else cursor_oh <= cursor_oh >> 1;
          end
        end
        CHECK: if (valid) begin
          state     <= IDLE;
          date_bcd  <= work;
          done      <= 1'b1;
          editing   <= 1'b0;
          cursor_oh <= '0;
        end else begin
          state     <= EDIT;
          err_date  <= 1'b1;
          cursor_oh <= 6'b100000;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_bcd_date_entry.sv
// tb_bcd_date_entry: directed, table-driven check of date entry, validation, debounce, cancel and reset
module tb_bcd_date_entry;
  localparam int D = 4;
  logic        clk = 1'b0, reset_n = 1'b0, key_next_n = 1'b1, key_cancel_n = 1'b1;
  logic [3:0]  sw_digit = 4'd0;
  logic [23:0] disp_bcd, date_bcd;
  logic [5:0]  cursor_oh;
  logic        editing, done, err_digit, err_date;
  int          n_cmp = 0, n_bad = 0, n_done = 0, exp_done = 0;
  logic [23:0] exp_date = 24'h061300;
  typedef struct {logic [23:0] d; logic ok;} vec_t;
  vec_t v[12];

  bcd_date_entry #(.DEBOUNCE_CYCLES(D), .DEFAULT_DATE(24'h061300)) dut (
    .clk(clk), .reset_n(reset_n), .key_next_n(key_next_n), .key_cancel_n(key_cancel_n),
    .sw_digit(sw_digit), .disp_bcd(disp_bcd), .date_bcd(date_bcd), .cursor_oh(cursor_oh),
    .editing(editing), .done(done), .err_digit(err_digit), .err_date(err_date));

  always #5 clk = ~clk;
  always @(posedge clk) if (reset_n && done) n_done++;

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic keys(input logic nx, input logic cn, input logic [3:0] d);
    sw_digit = d;
    cyc(3);
    key_next_n   = ~nx;
    key_cancel_n = ~cn;
    cyc(D + 8);
    key_next_n   = 1'b1;
    key_cancel_n = 1'b1;
    cyc(D + 8);
  endtask
  task automatic enter(input logic [23:0] d);
    keys(1'b1, 1'b0, 4'd0);
    for (int i = 5; i >= 0; i--) keys(1'b1, 1'b0, d[i*4 +: 4]);
  endtask

  initial begin
    v[0]  = '{24'h022923, 1'b0};
    v[1]  = '{24'h130100, 1'b0};
    v[2]  = '{24'h043110, 1'b0};
    v[3]  = '{24'h022924, 1'b1};
    v[4]  = '{24'h022900, 1'b1};
    v[5]  = '{24'h003110, 1'b0};
    v[6]  = '{24'h113110, 1'b0};
    v[7]  = '{24'h123110, 1'b1};
    v[8]  = '{24'h010010, 1'b0};
    v[9]  = '{24'h043010, 1'b1};
    v[10] = '{24'h022925, 1'b0};
    v[11] = '{24'h022812, 1'b1};
    cyc(3);
    chk("reset date", date_bcd, 24'h061300);
    chk("reset disp", disp_bcd, 24'h061300);
    chk("reset editing", {23'd0, editing}, 24'd0);
    chk("reset cursor", {18'd0, cursor_oh}, 24'd0);
    reset_n = 1'b1;
    cyc(3);
    keys(1'b1, 1'b0, 4'd0);
    chk("start cursor", {18'd0, cursor_oh}, 24'h20);
    chk("start editing", {23'd0, editing}, 24'd1);
    for (int i = 0; i < 6; i++) begin
      logic [23:0] d;
      d = 24'h122599;
      keys(1'b1, 1'b0, d[(5-i)*4 +: 4]);
      chk("step cursor", {18'd0, cursor_oh}, i == 5 ? 24'd0 : 24'(6'b100000 >> (i + 1)));
    end
    exp_date = 24'h122599;
    exp_done++;
    chk("commit date", date_bcd, exp_date);
    chk("done count", 24'(n_done), 24'(exp_done));
    keys(1'b1, 1'b0, 4'd0);
    sw_digit = 4'd3;
    cyc(3);
    for (int i = 0; i < 3; i++) begin
      key_next_n = 1'b0;
      cyc(2);
      key_next_n = 1'b1;
      cyc(2);
    end
    key_next_n = 1'b0;
    cyc(D + 8);
    key_next_n = 1'b1;
    cyc(D + 8);
    chk("bounce cursor", {18'd0, cursor_oh}, 24'h10);
    chk("bounce digit", {20'd0, disp_bcd[23:20]}, 24'd3);
    keys(1'b0, 1'b1, 4'd0);
    chk("cancel1 editing", {23'd0, editing}, 24'd0);
    keys(1'b1, 1'b0, 4'd0);
    keys(1'b1, 1'b0, 4'hA);
    chk("bad digit err", {23'd0, err_digit}, 24'd1);
    chk("bad digit cursor", {18'd0, cursor_oh}, 24'h20);
    keys(1'b1, 1'b0, 4'd1);
    chk("good digit err", {23'd0, err_digit}, 24'd0);
    chk("good digit cursor", {18'd0, cursor_oh}, 24'h10);
    keys(1'b0, 1'b1, 4'd0);
    for (int k = 0; k < 12; k++) begin
      enter(v[k].d);
      if (v[k].ok) begin
        exp_date = v[k].d;
        exp_done++;
        chk("vec editing", {23'd0, editing}, 24'd0);
        chk("vec err_date", {23'd0, err_date}, 24'd0);
      end else begin
        chk("vec err_date", {23'd0, err_date}, 24'd1);
        chk("vec cursor", {18'd0, cursor_oh}, 24'h20);
        chk("vec kept work", disp_bcd, v[k].d);
        keys(1'b0, 1'b1, 4'd0);
      end
      chk("vec date", date_bcd, exp_date);
      chk("vec done count", 24'(n_done), 24'(exp_done));
    end
    keys(1'b1, 1'b0, 4'd0);
    keys(1'b1, 1'b0, 4'd9);
    keys(1'b1, 1'b0, 4'd9);
    keys(1'b1, 1'b0, 4'd9);
    keys(1'b1, 1'b1, 4'd0);
    chk("both cancel editing", {23'd0, editing}, 24'd0);
    chk("both cancel cursor", {18'd0, cursor_oh}, 24'd0);
    chk("both cancel date", date_bcd, exp_date);
    chk("both cancel disp", disp_bcd, exp_date);
    keys(1'b1, 1'b1, 4'd0);
    chk("both idle editing", {23'd0, editing}, 24'd1);
    chk("both idle cursor", {18'd0, cursor_oh}, 24'h20);
    keys(1'b1, 1'b0, 4'd0);
    keys(1'b1, 1'b0, 4'd1);
    reset_n = 1'b0;
    cyc(1);
    chk("midreset date", date_bcd, 24'h061300);
    chk("midreset disp", disp_bcd, 24'h061300);
    chk("midreset cursor", {18'd0, cursor_oh}, 24'd0);
    chk("midreset editing", {23'd0, editing}, 24'd0);
    key_next_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc(D + 12);
    chk("held key no press", {23'd0, editing}, 24'd0);
    key_next_n = 1'b1;
    cyc(D + 8);
    keys(1'b1, 1'b0, 4'd0);
    chk("press after release", {23'd0, editing}, 24'd1);
    chk("final done count", 24'(n_done), 24'(exp_done));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
